// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: issues sequential word fetches to a 1-cycle SRAM,
// buffers {pc, instruction} in a small FIFO and hands them to decode.
module ifetch_unit #(
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [PC_W-1:0] ins_a,
  output logic            ins_e,
  input  logic [31:0]     ins,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_ins
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = PC_W + 32;

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_inflight;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [EW-1:0]   r_mem [FIFO_DEPTH];

  logic            w_pop;
  logic            w_push;
  logic [CW:0]     w_occ;
  logic [EW-1:0]   w_head;
  logic [PW-1:0]   w_rd_nxt;
  logic [PW-1:0]   w_wr_nxt;
  logic            w_unused_lsbs;

  assign w_unused_lsbs = ^redirect_pc[1:0];

  assign out_valid = ~rstn & (r_count != '0) & ~redirect_valid;
  assign w_pop     = out_valid & out_ready;
  // A response arriving in a redirect cycle belongs to the old stream and is dropped.
  assign w_push    = ~rstn & r_inflight & ~redirect_valid;

  // Occupancy counts the outstanding request so the FIFO can never overflow.
  assign w_occ = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign ins_e = ~rstn & (redirect_valid | (w_occ < (CW+1)'(FIFO_DEPTH)));
  assign ins_a = rstn           ? RESET_PC :
                 redirect_valid ? {redirect_pc[PC_W-1:2], 2'b00} :
                                  r_fetch_pc;

  assign w_rd_nxt = (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_nxt = (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);

  assign w_head  = r_mem[r_rd_ptr];
  assign out_pc  = (r_count != '0) ? w_head[EW-1:32] : '0;
  assign out_ins = (r_count != '0) ? w_head[31:0]    : '0;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= ins_e;
      if (ins_e) begin
        r_fetch_pc <= ins_a + PC_W'(4);
        r_req_pc   <= ins_a;
      end
      if (redirect_valid) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= w_wr_nxt;
        if (w_pop)  r_rd_ptr <= w_rd_nxt;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Payload storage carries no reset; r_count qualifies every entry.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_req_pc, ins};
  end

  always_ff @(posedge clk) begin
    if (!rstn) assert (r_count <= CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: cycle-exact vector table for reset/stream/backpressure,
// then a PC scoreboard across redirects, address wrap and mid-stream reset.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins = 32'hDEADBEEF;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [31:0] out_ins;

  int total = 0;
  int bad = 0;
  logic [15:0] q[$];

  ifetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .ins_a(ins_a), .ins_e(ins_e), .ins(ins),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [15:0] a);
    return 32'h00000013 + 32'(a >> 2) * 32'h00100080;
  endfunction

  // SRAM: data for a request is visible after the issuing edge; junk otherwise.
  always @(posedge clk) ins <= ins_e ? word(ins_a) : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [15:0] rpc);
    @(negedge clk);
    rstn = r;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic mon();
    logic [15:0] e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h expected no delivery", out_pc);
      end else begin
        e = q.pop_front();
        chk("sb_pc", 32'(out_pc), 32'(e));
        chk("sb_ins", out_ins, word(e));
      end
    end
  endtask

  task automatic run_sb(input string nm);
    int lat;
    lat = -1;
    for (int k = 1; k <= 30 && q.size() != 0; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0);
      if (lat < 0 && out_valid) lat = k;
      mon();
    end
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, q.size());
      q.delete();
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e;
    logic [15:0] a;
    logic        v;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h000C, 1'b1, 16'h0004};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0008};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0000};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0000};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 16'h000C, 1'b1, 16'h0004};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0008};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h000C};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, 1'b0, 16'h0);
      chk($sformatf("vec%0d_ins_e", i), 32'(ins_e), 32'(tbl[i].e));
      chk($sformatf("vec%0d_ins_a", i), 32'(ins_a), 32'(tbl[i].a));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v || tbl[i].rst) begin
        chk($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(tbl[i].pc));
        chk($sformatf("vec%0d_ins", i), out_ins, tbl[i].rst ? 32'h0 : word(tbl[i].pc));
      end
    end

    // Fill the FIFO under backpressure, then redirect.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk("pre_redir_valid", 32'(out_valid), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0103);
    q.delete();
    q.push_back(16'h0100); q.push_back(16'h0104); q.push_back(16'h0108); q.push_back(16'h010C);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_ins_e", 32'(ins_e), 32'd1);
    chk("redir_ins_a", 32'(ins_a), 32'h0100);
    mon();
    run_sb("redir");

    // Redirect near the top of the address space with a request in flight.
    cyc(1'b0, 1'b1, 1'b1, 16'hFFF8);
    q.delete();
    q.push_back(16'hFFF8); q.push_back(16'hFFFC); q.push_back(16'h0000); q.push_back(16'h0004);
    chk("wrap_ins_a", 32'(ins_a), 32'hFFF8);
    chk("wrap_ins_e", 32'(ins_e), 32'd1);
    mon();
    run_sb("wrap");

    // Back-to-back redirects: 0x40 must never be delivered.
    cyc(1'b0, 1'b1, 1'b1, 16'h0040);
    q.delete();
    mon();
    cyc(1'b0, 1'b1, 1'b1, 16'h0080);
    q.push_back(16'h0080); q.push_back(16'h0084); q.push_back(16'h0088);
    chk("b2b_ins_a", 32'(ins_a), 32'h0080);
    chk("b2b_valid", 32'(out_valid), 32'd0);
    mon();
    run_sb("b2b");

    // Mid-stream reset with a non-empty FIFO.
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk("prerst_valid", 32'(out_valid), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ins_e", 32'(ins_e), 32'd0);
    chk("midrst_pc", 32'(out_pc), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    q.delete();
    q.push_back(16'h0000); q.push_back(16'h0004); q.push_back(16'h0008);
    chk("restart_ins_e", 32'(ins_e), 32'd1);
    chk("restart_ins_a", 32'(ins_a), 32'h0000);
    mon();
    run_sb("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
